// File: rtl/cpu_run_ctrl.sv
// Run-control and watchdog for the 16-bit CPU: sequences CPU reset/enable,
// counts RUN cycles, ends a run on HALT or budget expiry, and traces outvalue changes.
module cpu_run_ctrl #(
   parameter int                 DATA_W      = 16,
   parameter int                 OPC_W       = 4,
   parameter logic [OPC_W-1:0]   HALT_OPC    = '0,
   parameter int                 MAX_CYCLES  = 160,
   parameter int                 RST_CYCLES  = 2,
   parameter int                 CNT_W       = 16,
   parameter int                 TRACE_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] outvalue,
   output logic              cpu_reset,
   output logic              cpu_en,
   output logic              running,
   output logic              done,
   output logic              halted,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count,
   input  logic              trace_rd,
   output logic [DATA_W-1:0] trace_data,
   output logic              trace_empty,
   output logic              trace_full,
   output logic              trace_overflow
);

   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RSTC, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [RC_W-1:0]   rcnt_q, rcnt_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem [TRACE_DEPTH];

   logic              fifo_empty, fifo_full;
   logic              capture, do_wr, do_rd, begin_run;
   logic [OPC_W-1:0]  opcode;
   logic              unused_instr;

   assign opcode       = instr[DATA_W-1 -: OPC_W];
   assign unused_instr = ^instr[DATA_W-OPC_W-1:0];

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign capture = (state_q == S_RUN) && (outvalue != prev_q);
   assign do_rd   = trace_rd && !fifo_empty;
   assign do_wr   = capture && (!fifo_full || do_rd);

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      cycle_d   = cycle_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      ovf_d     = ovf_q;
      prev_d    = prev_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      begin_run = 1'b0;

      if (capture) prev_d = outvalue;
      if (capture && !do_wr) ovf_d = 1'b1;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;

      case (state_q)
         S_IDLE: if (start) begin_run = 1'b1;
         S_RSTC: begin
            if (rcnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_RUN;
            else                                 rcnt_d  = rcnt_q + 1'b1;
         end
         S_RUN: begin
            cycle_d = cycle_q + 1'b1;
            // HALT takes priority over budget expiry in the same cycle.
            if (instr_valid && (opcode == HALT_OPC)) begin
               state_d  = S_DONE;
               halted_d = 1'b1;
            end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: if (start) begin_run = 1'b1;
         default: state_d = S_IDLE;
      endcase

      if (begin_run) begin
         state_d   = S_RSTC;
         rcnt_d    = '0;
         cycle_d   = '0;
         halted_d  = 1'b0;
         timeout_d = 1'b0;
         ovf_d     = 1'b0;
         prev_d    = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rcnt_q    <= '0;
         cycle_q   <= '0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         ovf_q     <= 1'b0;
         prev_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         cycle_q   <= cycle_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         ovf_q     <= ovf_d;
         prev_q    <= prev_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset: contents are only visible while non-empty.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q[PTR_W-1:0]] <= outvalue;
   end

   assign cpu_reset      = (state_q == S_IDLE) || (state_q == S_RSTC);
   assign cpu_en         = (state_q == S_RUN);
   assign running        = (state_q == S_RUN);
   assign done           = (state_q == S_DONE);
   assign halted         = halted_q;
   assign timeout        = timeout_q;
   assign cycle_count    = cycle_q;
   assign trace_data     = fifo_empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];
   assign trace_empty    = fifo_empty;
   assign trace_full     = fifo_full;
   assign trace_overflow = ovf_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl; trace FIFO output checked against a queue scoreboard.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, instr_valid, trace_rd;
   logic [15:0] instr, outvalue;
   logic        cpu_reset, cpu_en, running, done, halted, timeout;
   logic [15:0] cycle_count, trace_data;
   logic        trace_empty, trace_full, trace_overflow;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];
   logic [15:0] prev_m;
   logic [15:0] e;
   logic [15:0] ovals [5];

   cpu_run_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid),
      .instr(instr), .outvalue(outvalue), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
      .running(running), .done(done), .halted(halted), .timeout(timeout),
      .cycle_count(cycle_count), .trace_rd(trace_rd), .trace_data(trace_data),
      .trace_empty(trace_empty), .trace_full(trace_full),
      .trace_overflow(trace_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_cpu_reset"}, cpu_reset, 1);
      check({p, "_cpu_en"}, cpu_en, 0);
      check({p, "_running"}, running, 0);
      check({p, "_done"}, done, 0);
      check({p, "_halted"}, halted, 0);
      check({p, "_timeout"}, timeout, 0);
      check({p, "_cycle_count"}, cycle_count, 0);
      check({p, "_trace_empty"}, trace_empty, 1);
      check({p, "_trace_full"}, trace_full, 0);
      check({p, "_trace_overflow"}, trace_overflow, 0);
      check({p, "_trace_data"}, trace_data, 0);
   endtask

   // Show-ahead pop: head must match scoreboard front before the read edge.
   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) check({tag, "_sb_has_entry"}, trace_empty, 1);
      else begin
         e = exp_q.pop_front();
         check(tag, trace_data, e);
         trace_rd = 1'b1;
         tick();
         trace_rd = 1'b0;
      end
   endtask

   task automatic start_run(input string p);
      outvalue    = 16'h0000;
      instr_valid = 1'b0;
      instr       = 16'h1000;
      prev_m      = 16'h0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({p, "_rstc_cpu_reset"}, cpu_reset, 1);
      check({p, "_rstc_cpu_en"}, cpu_en, 0);
      check({p, "_rstc_halted_clr"}, halted, 0);
      check({p, "_rstc_timeout_clr"}, timeout, 0);
      check({p, "_rstc_count_clr"}, cycle_count, 0);
      check({p, "_rstc_empty"}, trace_empty, 1);
      check({p, "_rstc_ovf_clr"}, trace_overflow, 0);
      tick();
      check({p, "_rstc2_cpu_reset"}, cpu_reset, 1);
      tick();
      check({p, "_run_cpu_reset"}, cpu_reset, 0);
      check({p, "_run_cpu_en"}, cpu_en, 1);
      check({p, "_run_running"}, running, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instr_valid = 1'b0; trace_rd = 1'b0;
      instr = 16'h1000; outvalue = 16'h0000;
      ovals[0] = 16'h0000; ovals[1] = 16'h0005; ovals[2] = 16'h0005;
      ovals[3] = 16'h0009; ovals[4] = 16'h0003;
      tick();
      check_reset_vals("rst");
      reset = 1'b0;
      tick();
      check_reset_vals("idle");

      // Run 1: MOV/ADD stream, HALT on RUN cycle 10, trace 0,5,5,9,3
      start_run("r1");
      for (int c = 0; c <= 10; c++) begin
         instr_valid = (c != 4);
         instr = (c == 10) ? 16'h0005 : ((c == 4) ? 16'h0000 : 16'h1000 + 16'(c));
         outvalue = (c < 5) ? ovals[c] : 16'h0003;
         if (outvalue != prev_m) begin
            exp_q.push_back(outvalue);
            prev_m = outvalue;
         end
         tick();
      end
      instr_valid = 1'b0;
      check("r1_done", done, 1);
      check("r1_halted", halted, 1);
      check("r1_timeout", timeout, 0);
      check("r1_count", cycle_count, 11);
      check("r1_cpu_en", cpu_en, 0);
      check("r1_cpu_reset", cpu_reset, 0);
      check("r1_sb_depth", exp_q.size(), 3);
      outvalue = 16'h0077;
      tick();
      check("r1_done_hold_count", cycle_count, 11);
      pop_check("r1_pop0");
      pop_check("r1_pop1");
      pop_check("r1_pop2");
      check("r1_empty", trace_empty, 1);
      check("r1_empty_data", trace_data, 0);
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
      check("r1_rd_empty_ignored", trace_empty, 1);

      // Run 2: overflow, then pop+push while full
      start_run("r2");
      for (int v = 1; v <= 10; v++) begin
         instr_valid = 1'b1;
         instr = 16'h2000 + 16'(v);
         outvalue = 16'(v);
         if (v <= 8) exp_q.push_back(16'(v));
         tick();
      end
      check("r2_full", trace_full, 1);
      check("r2_ovf", trace_overflow, 1);
      check("r2_running", running, 1);
      outvalue = 16'h000b;
      e = exp_q.pop_front();
      check("r2_head_first", trace_data, e);
      exp_q.push_back(16'h000b);
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
      check("r2_full_after_rdwr", trace_full, 1);
      instr = 16'h0000;
      tick();
      check("r2_halted", halted, 1);
      check("r2_ovf_hold", trace_overflow, 1);
      for (int i = 0; i < 7; i++) pop_check($sformatf("r2_pop%0d", i));
      check("r2_not_empty", trace_empty, 0);
      check("r2_last", trace_data, exp_q[0]);
      exp_q.delete();

      // Run 3: no HALT -> timeout; start mid-run ignored
      start_run("r3");
      instr_valid = 1'b1;
      instr = 16'h3000;
      for (int c = 0; c < 160; c++) begin
         start = (c == 20);
         tick();
         if (c == 158) begin
            check("r3_count159", cycle_count, 159);
            check("r3_still_running", running, 1);
         end
      end
      start = 1'b0;
      check("r3_done", done, 1);
      check("r3_timeout", timeout, 1);
      check("r3_halted", halted, 0);
      check("r3_count", cycle_count, 160);
      check("r3_no_capture", trace_empty, 1);

      // Run 4: HALT on the last budget cycle
      start_run("r4");
      instr_valid = 1'b1;
      for (int c = 0; c < 160; c++) begin
         instr = (c == 159) ? 16'h0abc : 16'h4000;
         tick();
      end
      check("r4_done", done, 1);
      check("r4_halted", halted, 1);
      check("r4_timeout", timeout, 0);
      check("r4_count", cycle_count, 160);

      // Run 5: async reset at RUN cycle 50
      start_run("r5");
      instr_valid = 1'b1;
      instr = 16'h5000;
      for (int c = 0; c < 50; c++) begin
         outvalue = 16'(c + 1);
         tick();
      end
      check("r5_count50", cycle_count, 50);
      check("r5_full", trace_full, 1);
      #2 reset = 1'b1;
      #1 check_reset_vals("r5_async");
      tick();
      reset = 1'b0;
      instr_valid = 1'b0;
      tick();
      check_reset_vals("r5_post");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run-control and watchdog block for the 16-bit CPU. It sequences CPU reset and enable, counts executed cycles and detects the HALT opcode (4'h0). It flags a timeout when no HALT arrives within a parametrised cycle budget. Every change on the CPU's outvalue bus is captured into a show-ahead trace FIFO so a bench or debug UART can read the run result after completion.

Parameters:
DATA_W, 16, instruction and outvalue width
OPC_W, 4, opcode field width, taken from instr[DATA_W-1 -: OPC_W]
HALT_OPC, 4'h0, opcode that ends a run
MAX_CYCLES, 160, run cycle budget before timeout (must be >= 1)
RST_CYCLES, 2, cycles cpu_reset is held at run start (must be >= 1)
CNT_W, 16, cycle counter width (must hold MAX_CYCLES)
TRACE_DEPTH, 8, trace FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse that starts a run; honoured in IDLE and DONE only
instr_valid  in  1  instr holds the instruction the CPU executes this cycle
instr  in  DATA_W  current instruction from CPU fetch
outvalue  in  DATA_W  CPU output bus
cpu_reset  out  1  reset to CPU
cpu_en  out  1  CPU clock enable
running  out  1  high in RUN
done  out  1  high in DONE
halted  out  1  sticky: run ended on HALT
timeout  out  1  sticky: run ended on budget expiry
cycle_count  out  CNT_W  RUN cycles elapsed in current/last run
trace_rd  in  1  pop trace head
trace_data  out  DATA_W  trace head (show-ahead); 0 when empty
trace_empty  out  1  FIFO empty
trace_full  out  1  FIFO full
trace_overflow  out  1  sticky: a capture was dropped because FIFO was full

Behaviour:
- Reset values: FSM=IDLE, cpu_reset=1, cpu_en=0, running=0, done=0, halted=0, timeout=0, cycle_count=0, trace_empty=1, trace_full=0, trace_overflow=0, trace_data=0, prev_out=0.
- States: IDLE -> RSTC -> RUN -> DONE. DONE returns to RSTC on start.
- IDLE: cpu_reset=1, cpu_en=0. start -> RSTC.
- RSTC: cpu_reset=1, cpu_en=0 for exactly RST_CYCLES cycles, then RUN.
- Entry to RSTC: clears cycle_count, halted, timeout, trace_overflow, FIFO pointers and prev_out (=0).
- RUN: cpu_reset=0, cpu_en=1, running=1. cycle_count increments every RUN cycle.
  - instr_valid && opcode==HALT_OPC -> DONE, halted=1.
  - Else if cycle_count==MAX_CYCLES-1 -> DONE, timeout=1. The transition cycle is counted, so cycle_count=MAX_CYCLES on timeout.
  - HALT and budget expiry in the same cycle: halted wins, timeout stays 0.
- DONE: cpu_en=0, cpu_reset=0 (CPU state preserved for inspection), done=1. cycle_count, flags and FIFO hold. start -> RSTC. start in RSTC/RUN is ignored.
- Capture: in RUN, when outvalue != prev_out, push outvalue and update prev_out.
  - A change at a value of 0 from the reset value is not captured.
  - No capture outside RUN.
- FIFO: write and read in the same cycle are both performed, including when full (count unchanged) and when empty (read ignored, write performed).
  - Push when full without a read: data dropped, trace_overflow=1.
  - trace_rd when empty: ignored.
  - Pointers wrap modulo TRACE_DEPTH.
- Asynchronous reset mid-run: immediate return to reset values. FIFO contents are lost.

Test Plan:
- Reset, start; CPU sequence MOV/ADD, then HALT at RUN cycle 10 -> cpu_reset high 2 cycles, then done=1, halted=1, timeout=0, cycle_count=11, cpu_en=0 next cycle.
- Start; no HALT -> timeout=1 after 160 RUN cycles, cycle_count=160, halted=0.
- HALT presented on RUN cycle 159 (last budget cycle) -> halted=1, timeout=0.
- outvalue sequence 0,5,5,9,0x0003 in RUN -> FIFO holds 5,9,3; pops return 5,9,3, then trace_empty=1 and trace_data=0.
- Ten distinct outvalue changes with TRACE_DEPTH=8 and no reads -> trace_full=1, trace_overflow=1, first eight values retained. Simultaneous pop and push when full -> count stays 8.
- Assert reset during RUN at cycle 50 -> all outputs return to reset values asynchronously. Restart via start from DONE clears flags, counter and FIFO.
